// File: rtl/topk_sort_ctrl_pkg.sv
// topk_pkg: shared types and defaults for the top-K sort sequencer.
//   state_e  : controller phase encoding
//   *_DEF    : default geometry (K, DW, IW, CNT_W)
//   topk_min : drain-count helper, D = min(K, N)
package topk_pkg;
  localparam int K_DEF     = 20;
  localparam int DW_DEF    = 32;
  localparam int IW_DEF    = 32;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    LOAD   = 3'd2,
    SETTLE = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } state_e;

  function automatic int unsigned topk_min(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction
endpackage

// File: rtl/topk_sort_ctrl_if.sv
// topk_sort_ctrl_if: job config, score input stream, sorter control/readback
// and ranked result stream of the top-K sequencer.
//   master : controller side (drives busy/done, s_ready, sort_*, rd_sel, m_*)
//   slave  : environment side (config, score source, sorter, result sink)
interface topk_sort_ctrl_if #(
  parameter int K     = topk_pkg::K_DEF,
  parameter int DW    = topk_pkg::DW_DEF,
  parameter int IW    = topk_pkg::IW_DEF,
  parameter int CNT_W = topk_pkg::CNT_W_DEF,
  parameter int RW    = (K > 1) ? $clog2(K) : 1
);
  logic             cfg_start;
  logic [CNT_W-1:0] cfg_num;
  logic             cfg_asce;
  logic             busy;
  logic             done;
  logic             s_valid;
  logic             s_ready;
  logic [DW-1:0]    s_data;
  logic             sort_clear;
  logic             sort_start;
  logic             sort_asce;
  logic             sort_we;
  logic [DW-1:0]    sort_in;
  logic [IW-1:0]    sort_index;
  logic [RW-1:0]    rd_sel;
  logic [DW-1:0]    rd_value;
  logic [IW-1:0]    rd_index;
  logic             m_valid;
  logic             m_ready;
  logic [DW-1:0]    m_value;
  logic [IW-1:0]    m_index;
  logic [RW-1:0]    m_rank;

  modport master (
    input  cfg_start, cfg_num, cfg_asce, s_valid, s_data, rd_value, rd_index, m_ready,
    output busy, done, s_ready, sort_clear, sort_start, sort_asce, sort_we,
           sort_in, sort_index, rd_sel, m_valid, m_value, m_index, m_rank
  );

  modport slave (
    output cfg_start, cfg_num, cfg_asce, s_valid, s_data, rd_value, rd_index, m_ready,
    input  busy, done, s_ready, sort_clear, sort_start, sort_asce, sort_we,
           sort_in, sort_index, rd_sel, m_valid, m_value, m_index, m_rank
  );
endinterface

// File: rtl/topk_sort_ctrl.sv
// topk_sort_ctrl: per-job sequencer for the top-K sorter.
// Latches a job (N, direction), clears the sorter, streams N scores into it
// tagged with their sample index, then drains min(K, N) ranked results.
// Ports:
//   clk  : clock
//   rst  : asynchronous reset, active low
//   bus  : topk_sort_ctrl_if.master (config, score stream, sorter, results)
// Build option TOPK_SORT_CTRL_RELU_EN: scores are signed and negatives are
// clamped to zero before entering the sorter; otherwise passed through as-is.
// All outputs are registered.
module topk_sort_ctrl
  import topk_pkg::*;
#(
  parameter int K     = K_DEF,
  parameter int DW    = DW_DEF,
  parameter int IW    = IW_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int RW    = (K > 1) ? $clog2(K) : 1
) (
  input logic              clk,
  input logic              rst,
  topk_sort_ctrl_if.master bus
);

  state_e           r_state;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_cnt;
  logic [RW-1:0]    r_last;      // rank of the final drained result, D-1
  logic             r_busy, r_done, r_s_ready;
  logic             r_clear, r_start, r_asce, r_we;
  logic [DW-1:0]    r_sort_in;
  logic [IW-1:0]    r_sort_index;
  logic [RW-1:0]    r_rd_sel;
  logic             r_m_valid;
  logic [DW-1:0]    r_m_value;
  logic [IW-1:0]    r_m_index;
  logic [RW-1:0]    r_m_rank;

  logic [DW-1:0]    w_score;
  logic             w_accept;

  assign w_accept = r_s_ready & bus.s_valid;

  always_comb begin
    w_score = bus.s_data;
`ifdef TOPK_SORT_CTRL_RELU_EN
    if (bus.s_data[DW-1]) w_score = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_num        <= '0;
      r_cnt        <= '0;
      r_last       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_s_ready    <= 1'b0;
      r_clear      <= 1'b0;
      r_start      <= 1'b0;
      r_asce       <= 1'b0;
      r_we         <= 1'b0;
      r_sort_in    <= '0;
      r_sort_index <= '0;
      r_rd_sel     <= '0;
      r_m_valid    <= 1'b0;
      r_m_value    <= '0;
      r_m_index    <= '0;
      r_m_rank     <= '0;
    end else begin
      // strobes default low; each state raises its own
      r_done  <= 1'b0;
      r_clear <= 1'b0;
      r_we    <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.cfg_start) begin
            if (bus.cfg_num != '0) begin
              r_num   <= bus.cfg_num;
              r_asce  <= bus.cfg_asce;
              r_cnt   <= '0;
              r_last  <= RW'(topk_min(32'(K), 32'(bus.cfg_num)) - 32'd1);
              r_busy  <= 1'b1;
              r_clear <= 1'b1;
              r_state <= CLEAR;
            end else begin
              // empty job: report completion without touching the sorter
              r_done <= 1'b1;
            end
          end
        end
        CLEAR: begin
          r_s_ready <= 1'b1;
          r_start   <= 1'b1;
          r_state   <= LOAD;
        end
        LOAD: begin
          if (w_accept) begin
            r_sort_in    <= w_score;
            r_sort_index <= IW'(r_cnt);
            r_we         <= 1'b1;
            r_cnt        <= r_cnt + CNT_W'(1);
            if (r_cnt == r_num - CNT_W'(1)) begin
              r_s_ready <= 1'b0;
              r_state   <= SETTLE;
            end
          end
        end
        SETTLE: begin
          // final sort_we is on the bus this cycle; readback starts after it
          r_rd_sel <= '0;
          r_state  <= DRAIN;
        end
        DRAIN: begin
          if (!r_m_valid) begin
            r_m_value <= bus.rd_value;
            r_m_index <= bus.rd_index;
            r_m_rank  <= r_rd_sel;
            r_m_valid <= 1'b1;
          end else if (bus.m_ready) begin
            r_m_valid <= 1'b0;
            if (r_rd_sel == r_last) begin
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_start  <= 1'b0;
              r_rd_sel <= '0;
              r_state  <= DONE;
            end else begin
              r_rd_sel <= r_rd_sel + RW'(1);
            end
          end
        end
        DONE: begin
          r_asce  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.s_ready    = r_s_ready;
  assign bus.sort_clear = r_clear;
  assign bus.sort_start = r_start;
  assign bus.sort_asce  = r_asce;
  assign bus.sort_we    = r_we;
  assign bus.sort_in    = r_sort_in;
  assign bus.sort_index = r_sort_index;
  assign bus.rd_sel     = r_rd_sel;
  assign bus.m_valid    = r_m_valid;
  assign bus.m_value    = r_m_value;
  assign bus.m_index    = r_m_index;
  assign bus.m_rank     = r_m_rank;

endmodule
